traffic_ctrl_param: RTL and testbench
=====================================

TRAFFIC_CTRL_PARAM -- requirements
Module: traffic_ctrl_param

Interface
Parameters:
REQ-001 PRE_DIV, default 8: prescaler divide ratio (>=2); one TICK every PRE_DIV enabled cycles.
REQ-002 TW, default 6: phase-timer width in bits; every T_* and G* parameter SHALL be < 2^TW.
REQ-003 GMIN, default 20: minimum green length in ticks, for both main and side.
REQ-004 GMAX, default 40: maximum side-green length in ticks; GMAX >= GMIN.
REQ-005 T_YEL, default 4: yellow length in ticks.
REQ-006 T_AR, default 2: all-red clearance length in ticks.

Ports (name, direction, width, meaning):
REQ-007 CK  in  1  sole clock, rising edge.
REQ-008 RN  in  1  reset, asynchronous, active-low.
REQ-009 CLR  in  1  synchronous clear, active-high; priority over all other inputs.
REQ-010 EN  in  1  count enable; low freezes prescaler, timer and FSM.
REQ-011 SIDE_REQ  in  1  side-road vehicle request, level or pulse.
REQ-012 PED_REQ  in  1  pedestrian request, level or pulse.
REQ-013 FLASH  in  1  fault mode request.
REQ-014 MAIN_LT  out  3  main-road lamps {G,Y,R}.
REQ-015 SIDE_LT  out  3  side-road lamps {G,Y,R}.
REQ-016 PED_WALK  out  1  pedestrian walk lamp.
REQ-017 STATE  out  3  current FSM state code.
REQ-018 TICK  out  1  prescaler tick strobe.

Function
REQ-019 Prescaler: counts 0..PRE_DIV-1 while EN=1, then wraps; TICK=1 for exactly the cycle in which count=PRE_DIV-1 and EN=1.
REQ-020 Timer: TW bits; cleared to 0 on every state change; otherwise increments on TICK and saturates at 2^TW-1.
REQ-021 States and codes: MG=0, MY=1, AR1=2, SG=3, SY=4, AR2=5, FL=6; codes 7 and unused SHALL recover to MG on the next edge.
REQ-022 Non-FL transitions occur only on a CK edge with TICK=1; "timer=N-1 on TICK" means the phase lasts exactly N ticks.
REQ-023 MG->MY when timer>=GMIN-1 and (side_pend|ped_pend); with no pending request MG holds indefinitely.
REQ-024 MY->AR1 at timer=T_YEL-1; AR1->SG at timer=T_AR-1; SY->AR2 at timer=T_YEL-1; AR2->MG at timer=T_AR-1.
REQ-025 SG->SY at timer=GMIN-1 if SIDE_REQ=0 on that edge; otherwise SG extends, leaving at the first later TICK with SIDE_REQ=0 or at timer=GMAX-1, whichever comes first.
REQ-026 side_pend / ped_pend: set by SIDE_REQ / PED_REQ high on any edge; both cleared on the edge entering SG; clear wins over a simultaneous set.
REQ-027 ped_srv: captures ped_pend on entry to SG; cleared on exit from SG; PED_WALK = (STATE==SG) & ped_srv.
REQ-028 FLASH=1: enter FL from any state on the next CK edge, TICK not required; timer and pendings keep their values.
REQ-029 In FL, a blink bit toggles on each TICK.
REQ-030 In FL, MAIN_LT = SIDE_LT = {0,blink,0} and PED_WALK=0.
REQ-031 FLASH=0 in FL: next edge enters AR2 with timer=0 and blink=0.
REQ-032 Lamp decode (Moore, from state register only): MG main=100 side=001; MY main=010 side=001; AR1, AR2 both 001; SG main=001 side=100; SY main=001 side=010.
REQ-033 No state SHALL ever drive G or Y on both roads at once, except the FL yellow flash.
REQ-034 EN=0: prescaler, timer and blink hold, TICK=0, FSM holds; pendings still latch requests; FLASH entry and exit still apply.

Reset
REQ-035 RN=0 asynchronously forces state=MG, prescaler=0, timer=0, pendings=0, ped_srv=0, blink=0.
REQ-036 Outputs during and after RN=0: MAIN_LT=100, SIDE_LT=001, PED_WALK=0, STATE=0, TICK=0.
REQ-037 CLR=1 on an edge forces the REQ-035 register values synchronously, regardless of EN and FLASH.
REQ-038 Reset or CLR asserted mid-phase aborts the phase immediately; no yellow or all-red is inserted.

Verification
REQ-039 Defaults, EN=1, no requests for 1000 cycles -> STATE stays 0; TICK pulses every 8th cycle, first at cycle 8 after RN release.
REQ-040 Defaults, SIDE_REQ pulse at cycle 10 -> MY entered on the edge of the 20th TICK; then AR1 after 32 cycles, SG after 16 cycles, SY after 20 ticks, AR2 after 4 ticks, MG after 2 ticks.
REQ-041 SIDE_REQ held high throughout SG -> SG lasts exactly 40 ticks.
REQ-042 SIDE_REQ released at SG timer=25 -> SY entered on the following TICK.
REQ-043 PED_REQ pulse during MY -> PED_WALK=1 for the whole next SG phase and 0 elsewhere.
REQ-044 PED_REQ on the SG-entry edge -> request not re-latched.
REQ-045 FLASH asserted mid-SG -> lamps alternate 010 / 000 per TICK; on deassertion, AR2 for 2 ticks then MG.
REQ-046 RN pulsed low mid-SY -> outputs reach reset values without waiting for CK.
REQ-047 CLR with EN=0 -> state 0 on the next edge.
REQ-048 EN low for 50 cycles mid-MY -> timer frozen; the phase completes after the remaining ticks once EN returns.

Source files
------------

// File: rtl/traffic_ctrl_param.sv
// Parameterised two-road traffic light controller with pedestrian service,
// side-road green extension, flashing fault mode and a tick prescaler.
// Phase lengths are measured in prescaler ticks; the FSM only advances on a
// tick edge except for fault-mode entry/exit and invalid-state recovery.
module traffic_ctrl_param #(
    parameter int PRE_DIV = 8,
    parameter int TW      = 6,
    parameter int GMIN    = 20,
    parameter int GMAX    = 40,
    parameter int T_YEL   = 4,
    parameter int T_AR    = 2
) (
    input  logic       CK,
    input  logic       RN,
    input  logic       CLR,
    input  logic       EN,
    input  logic       SIDE_REQ,
    input  logic       PED_REQ,
    input  logic       FLASH,
    output logic [2:0] MAIN_LT,
    output logic [2:0] SIDE_LT,
    output logic       PED_WALK,
    output logic [2:0] STATE,
    output logic       TICK
);

    localparam int PW = $clog2(PRE_DIV);

    localparam logic [PW-1:0] PRE_LAST  = PW'(PRE_DIV - 1);
    localparam logic [TW-1:0] GMIN_LAST = TW'(GMIN - 1);
    localparam logic [TW-1:0] GMAX_LAST = TW'(GMAX - 1);
    localparam logic [TW-1:0] YEL_LAST  = TW'(T_YEL - 1);
    localparam logic [TW-1:0] AR_LAST   = TW'(T_AR - 1);
    localparam logic [TW-1:0] TMR_SAT   = '1;

    // Lamp encodings {G,Y,R}
    localparam logic [2:0] LAMP_G = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b001;

    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        AR2 = 3'd5,
        FL  = 3'd6
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   presc;
    logic [TW-1:0]   timer;
    logic            side_pend;
    logic            ped_pend;
    logic            ped_srv;
    logic            blink;
    logic            tick;
    logic            state_change;
    logic            enter_sg;
    logic            exit_sg;
    logic            exit_fl;

    assign tick         = EN && (presc == PRE_LAST);
    assign state_change = (state_d != state_q);
    assign enter_sg     = (state_d == SG) && (state_q != SG);
    assign exit_sg      = (state_q == SG) && (state_d != SG);
    assign exit_fl      = (state_q == FL) && (state_d != FL);

    assign TICK  = tick;
    assign STATE = state_q;

    // Prescaler: free-running modulo-PRE_DIV counter gated by EN
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            presc <= '0;
        end else if (CLR) begin
            presc <= '0;
        end else if (EN) begin
            if (presc == PRE_LAST) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= MG;
        end else if (CLR) begin
            state_q <= MG;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: tick-paced phases, fault mode overrides on any edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            MG: begin
                if (tick && (timer >= GMIN_LAST) && (side_pend || ped_pend)) begin
                    state_d = MY;
                end
            end
            MY: begin
                if (tick && (timer >= YEL_LAST)) begin
                    state_d = AR1;
                end
            end
            AR1: begin
                if (tick && (timer >= AR_LAST)) begin
                    state_d = SG;
                end
            end
            SG: begin
                if (tick && ((timer >= GMAX_LAST) ||
                             ((timer >= GMIN_LAST) && !SIDE_REQ))) begin
                    state_d = SY;
                end
            end
            SY: begin
                if (tick && (timer >= YEL_LAST)) begin
                    state_d = AR2;
                end
            end
            AR2: begin
                if (tick && (timer >= AR_LAST)) begin
                    state_d = MG;
                end
            end
            FL: begin
                if (!FLASH) begin
                    state_d = AR2;
                end
            end
            default: begin
                state_d = MG;
            end
        endcase
        if (FLASH && (state_q inside {MG, MY, AR1, SG, SY, AR2})) begin
            state_d = FL;
        end
    end

    // Phase timer: restarts on state change (except fault entry), saturating tick count
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            timer <= '0;
        end else if (CLR) begin
            timer <= '0;
        end else if (state_change) begin
            if (state_d != FL) begin
                timer <= '0;
            end
        end else if (tick && (timer != TMR_SAT)) begin
            timer <= timer + 1'b1;
        end
    end

    // Request latches: set by any request, cleared as side green begins
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            side_pend <= 1'b0;
            ped_pend  <= 1'b0;
        end else if (CLR) begin
            side_pend <= 1'b0;
            ped_pend  <= 1'b0;
        end else if (enter_sg) begin
            side_pend <= 1'b0;
            ped_pend  <= 1'b0;
        end else begin
            if (SIDE_REQ) begin
                side_pend <= 1'b1;
            end
            if (PED_REQ) begin
                ped_pend <= 1'b1;
            end
        end
    end

    // Pedestrian service flag held for the duration of one side-green phase
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            ped_srv <= 1'b0;
        end else if (CLR) begin
            ped_srv <= 1'b0;
        end else if (enter_sg) begin
            ped_srv <= ped_pend;
        end else if (exit_sg) begin
            ped_srv <= 1'b0;
        end
    end

    // Fault-mode blink phase, toggled per tick and restarted on leaving fault mode
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            blink <= 1'b0;
        end else if (CLR) begin
            blink <= 1'b0;
        end else if (exit_fl) begin
            blink <= 1'b0;
        end else if ((state_q == FL) && tick) begin
            blink <= ~blink;
        end
    end

    // Moore lamp decode; anything unexpected shows all-red
    always_comb begin
        MAIN_LT  = LAMP_R;
        SIDE_LT  = LAMP_R;
        PED_WALK = 1'b0;
        case (state_q)
            MG: begin
                MAIN_LT = LAMP_G;
            end
            MY: begin
                MAIN_LT = LAMP_Y;
            end
            SG: begin
                SIDE_LT  = LAMP_G;
                PED_WALK = ped_srv;
            end
            SY: begin
                SIDE_LT = LAMP_Y;
            end
            FL: begin
                MAIN_LT = {1'b0, blink, 1'b0};
                SIDE_LT = {1'b0, blink, 1'b0};
            end
            default: begin
                MAIN_LT = LAMP_R;
                SIDE_LT = LAMP_R;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed testbench for traffic_ctrl_param with default parameters.
// Time is counted in clock edges since reset release (cyc); with the default
// prescaler, tick edges fall on every multiple of 8.
module tb_traffic_ctrl_param;

    logic       CK;
    logic       RN;
    logic       CLR;
    logic       EN;
    logic       SIDE_REQ;
    logic       PED_REQ;
    logic       FLASH;
    logic [2:0] MAIN_LT;
    logic [2:0] SIDE_LT;
    logic       PED_WALK;
    logic [2:0] STATE;
    logic       TICK;

    int checks;
    int failures;
    int cyc;

    traffic_ctrl_param dut (
        .CK       (CK),
        .RN       (RN),
        .CLR      (CLR),
        .EN       (EN),
        .SIDE_REQ (SIDE_REQ),
        .PED_REQ  (PED_REQ),
        .FLASH    (FLASH),
        .MAIN_LT  (MAIN_LT),
        .SIDE_LT  (SIDE_LT),
        .PED_WALK (PED_WALK),
        .STATE    (STATE),
        .TICK     (TICK)
    );

    // Free-running clock, period 10
    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    // Advance to the falling edge after rising edge number target
    task automatic run_to(input int target);
        while (cyc < target) begin
            @(negedge CK);
            cyc++;
        end
    endtask

    // Apply reset and release it on a falling edge; cyc restarts at 0
    task automatic do_reset();
        CLR      = 1'b0;
        EN       = 1'b1;
        SIDE_REQ = 1'b0;
        PED_REQ  = 1'b0;
        FLASH    = 1'b0;
        RN       = 1'b0;
        repeat (3) @(negedge CK);
        RN  = 1'b1;
        cyc = 0;
    endtask

    // Side request pulse on edge 11 brings MY at edge 160 and SG at edge 208
    task automatic side_pulse();
        run_to(10);
        SIDE_REQ = 1'b1;
        run_to(11);
        SIDE_REQ = 1'b0;
    endtask

    task automatic test_reset();
        CLR = 1'b0; EN = 1'b1; SIDE_REQ = 1'b0; PED_REQ = 1'b0; FLASH = 1'b0;
        RN = 1'b0;
        repeat (2) @(negedge CK);
        checks++;
        if (STATE !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: got %0d expected 0", STATE);
        end
        checks++;
        if (MAIN_LT !== 3'b100 || SIDE_LT !== 3'b001) begin
            failures++;
            $display("[TB] FAIL reset_lamps: got main=%b side=%b expected main=100 side=001", MAIN_LT, SIDE_LT);
        end
        checks++;
        if (PED_WALK !== 1'b0 || TICK !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_walk_tick: got walk=%b tick=%b expected 0 0", PED_WALK, TICK);
        end
        RN  = 1'b1;
        cyc = 0;
    endtask

    task automatic test_tick_idle();
        do_reset();
        for (int n = 1; n <= 1000; n++) begin
            run_to(n);
            checks++;
            if (TICK !== ((n % 8) == 7)) begin
                failures++;
                $display("[TB] FAIL idle_tick at edge %0d: got %b expected %b", n, TICK, ((n % 8) == 7));
            end
            checks++;
            if (STATE !== 3'd0) begin
                failures++;
                $display("[TB] FAIL idle_state at edge %0d: got %0d expected 0", n, STATE);
            end
        end
    endtask

    task automatic test_side_cycle();
        int e[12] = '{159, 160, 191, 192, 207, 208, 367, 368, 399, 400, 415, 416};
        int s[12] = '{0,   1,   1,   2,   2,   3,   3,   4,   4,   5,   5,   0};
        do_reset();
        side_pulse();
        for (int i = 0; i < 12; i++) begin
            run_to(e[i]);
            checks++;
            if (STATE !== 3'(s[i])) begin
                failures++;
                $display("[TB] FAIL side_cycle_state at edge %0d: got %0d expected %0d", e[i], STATE, s[i]);
            end
            if (e[i] == 160) begin
                checks++;
                if (MAIN_LT !== 3'b010 || SIDE_LT !== 3'b001) begin
                    failures++;
                    $display("[TB] FAIL my_lamps: got main=%b side=%b expected 010 001", MAIN_LT, SIDE_LT);
                end
            end
            if (e[i] == 208) begin
                checks++;
                if (MAIN_LT !== 3'b001 || SIDE_LT !== 3'b100 || PED_WALK !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL sg_lamps: got main=%b side=%b walk=%b expected 001 100 0", MAIN_LT, SIDE_LT, PED_WALK);
                end
            end
            if (e[i] == 192) begin
                checks++;
                if (MAIN_LT !== 3'b001 || SIDE_LT !== 3'b001) begin
                    failures++;
                    $display("[TB] FAIL ar1_lamps: got main=%b side=%b expected 001 001", MAIN_LT, SIDE_LT);
                end
            end
        end
    endtask

    task automatic test_side_hold();
        int e[4] = '{208, 368, 527, 528};
        int s[4] = '{3,   3,   3,   4};
        do_reset();
        SIDE_REQ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_to(e[i]);
            checks++;
            if (STATE !== 3'(s[i])) begin
                failures++;
                $display("[TB] FAIL side_hold_state at edge %0d: got %0d expected %0d", e[i], STATE, s[i]);
            end
        end
        SIDE_REQ = 1'b0;
    endtask

    task automatic test_side_release();
        do_reset();
        SIDE_REQ = 1'b1;
        run_to(408);
        SIDE_REQ = 1'b0;
        run_to(415);
        checks++;
        if (STATE !== 3'd3) begin
            failures++;
            $display("[TB] FAIL release_hold: got %0d expected 3", STATE);
        end
        run_to(416);
        checks++;
        if (STATE !== 3'd4) begin
            failures++;
            $display("[TB] FAIL release_sy: got %0d expected 4", STATE);
        end
    endtask

    task automatic test_ped();
        int e[5] = '{208, 300, 367, 368, 416};
        logic w[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        side_pulse();
        run_to(170);
        PED_REQ = 1'b1;
        run_to(171);
        PED_REQ = 1'b0;
        run_to(207);
        checks++;
        if (PED_WALK !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ped_before_sg: got %b expected 0", PED_WALK);
        end
        PED_REQ = 1'b1;
        run_to(208);
        PED_REQ = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_to(e[i]);
            checks++;
            if (PED_WALK !== w[i]) begin
                failures++;
                $display("[TB] FAIL ped_walk at edge %0d: got %b expected %b", e[i], PED_WALK, w[i]);
            end
        end
        run_to(577);
        checks++;
        if (STATE !== 3'd0) begin
            failures++;
            $display("[TB] FAIL ped_no_relatch: got %0d expected 0", STATE);
        end
    endtask

    task automatic test_flash();
        int  e[4] = '{251, 256, 264, 272};
        logic [2:0] l[4] = '{3'b000, 3'b010, 3'b000, 3'b010};
        do_reset();
        side_pulse();
        run_to(250);
        FLASH = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_to(e[i]);
            checks++;
            if (STATE !== 3'd6 || MAIN_LT !== l[i] || SIDE_LT !== l[i] || PED_WALK !== 1'b0) begin
                failures++;
                $display("[TB] FAIL flash at edge %0d: got state=%0d main=%b side=%b walk=%b expected 6 %b %b 0",
                         e[i], STATE, MAIN_LT, SIDE_LT, PED_WALK, l[i], l[i]);
            end
        end
        run_to(275);
        FLASH = 1'b0;
        run_to(276);
        checks++;
        if (STATE !== 3'd5 || MAIN_LT !== 3'b001 || SIDE_LT !== 3'b001) begin
            failures++;
            $display("[TB] FAIL flash_exit: got state=%0d main=%b side=%b expected 5 001 001", STATE, MAIN_LT, SIDE_LT);
        end
        run_to(287);
        checks++;
        if (STATE !== 3'd5) begin
            failures++;
            $display("[TB] FAIL flash_ar2_hold: got %0d expected 5", STATE);
        end
        run_to(288);
        checks++;
        if (STATE !== 3'd0 || MAIN_LT !== 3'b100) begin
            failures++;
            $display("[TB] FAIL flash_to_mg: got state=%0d main=%b expected 0 100", STATE, MAIN_LT);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        side_pulse();
        run_to(380);
        checks++;
        if (STATE !== 3'd4) begin
            failures++;
            $display("[TB] FAIL async_pre_sy: got %0d expected 4", STATE);
        end
        #2;
        RN = 1'b0;
        #1;
        checks++;
        if (STATE !== 3'd0 || MAIN_LT !== 3'b100 || SIDE_LT !== 3'b001 || PED_WALK !== 1'b0 || TICK !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: got state=%0d main=%b side=%b walk=%b tick=%b expected 0 100 001 0 0",
                     STATE, MAIN_LT, SIDE_LT, PED_WALK, TICK);
        end
        @(negedge CK);
        RN  = 1'b1;
        cyc = 0;
    endtask

    task automatic test_clr_en0();
        do_reset();
        side_pulse();
        run_to(165);
        EN  = 1'b0;
        CLR = 1'b1;
        run_to(166);
        CLR = 1'b0;
        EN  = 1'b1;
        checks++;
        if (STATE !== 3'd0 || MAIN_LT !== 3'b100) begin
            failures++;
            $display("[TB] FAIL clr_en0: got state=%0d main=%b expected 0 100", STATE, MAIN_LT);
        end
        run_to(172);
        checks++;
        if (TICK !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clr_presc_early: got %b expected 0", TICK);
        end
        run_to(173);
        checks++;
        if (TICK !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clr_presc_tick: got %b expected 1", TICK);
        end
        run_to(330);
        checks++;
        if (STATE !== 3'd0) begin
            failures++;
            $display("[TB] FAIL clr_pend_cleared: got %0d expected 0", STATE);
        end
    endtask

    task automatic test_en_freeze();
        do_reset();
        side_pulse();
        run_to(170);
        EN = 1'b0;
        run_to(192);
        checks++;
        if (STATE !== 3'd1 || TICK !== 1'b0) begin
            failures++;
            $display("[TB] FAIL freeze_hold: got state=%0d tick=%b expected 1 0", STATE, TICK);
        end
        run_to(220);
        EN = 1'b1;
        run_to(241);
        checks++;
        if (STATE !== 3'd1) begin
            failures++;
            $display("[TB] FAIL freeze_resume_hold: got %0d expected 1", STATE);
        end
        run_to(242);
        checks++;
        if (STATE !== 3'd2) begin
            failures++;
            $display("[TB] FAIL freeze_resume_ar1: got %0d expected 2", STATE);
        end
    endtask

    // Scenario sequence
    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        test_reset();
        test_tick_idle();
        test_side_cycle();
        test_side_hold();
        test_side_release();
        test_ped();
        test_flash();
        test_async_reset();
        test_clr_en0();
        test_en_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
